dmem_access_unit: RTL and testbench

MEM-stage data-memory access controller that sits between the EX_MEM pipeline register and the MEM_WB pipeline register. It turns the load/store control and address from EX_MEM into a request/grant/response transaction on a variable-latency data bus, with byte-lane steering for stores. It stalls the pipeline for the duration of each access. It sign- or zero-extends load data into the word that MEM_WB captures as its read data.

---
 rtl/dmem_access_unit.sv | 140 ++++++++++++++
 tb/tb_dmem_access_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_unit.sv
// MEM-stage data-memory access controller: request/grant/rvalid bus sequencing,
// store byte-lane steering and load sign/zero extension into MEM_WB read data.
module dmem_access_unit (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        MemRead_i,
   input  logic        MemWrite_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   input  logic [2:0]  funct3_i,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   output logic [31:0] ReadData_o,
   output logic        stall_o,
   output logic        fault_o
);

   // state  | meaning
   // IDLE   | waiting for a load/store; launches or faults it
   // REQ    | bus request held until grant
   // WAIT   | read granted, waiting for rvalid
   // DONE   | one unstalled cycle so the pipeline advances
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]  state_q, state_d;
   logic [1:0]  lane_q;
   logic [2:0]  f3_q;
   logic        access, legal, aligned, start, bad;
   logic [3:0]  be_d;
   logic [31:0] wdata_d;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] ext_data;

   assign access = MemRead_i | MemWrite_i;

   always_comb begin
      legal = 1'b0;
      case (funct3_i)
         3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
         default: legal = 1'b0;
      endcase
   end

   always_comb begin
      aligned = 1'b1;
      case (funct3_i[1:0])
         2'b10:   aligned = (addr_i[1:0] == 2'b00);
         2'b01:   aligned = ~addr_i[0];
         default: aligned = 1'b1;
      endcase
   end

   assign start = (state_q == S_IDLE) && access && legal && aligned;
   assign bad   = (state_q == S_IDLE) && access && !(legal && aligned);

   always_comb begin
      be_d    = 4'b1111;
      wdata_d = wdata_i;
      case (funct3_i[1:0])
         2'b00: begin
            be_d    = 4'b0001 << addr_i[1:0];
            wdata_d = {4{wdata_i[7:0]}};
         end
         2'b01: begin
            be_d    = addr_i[1] ? 4'b1100 : 4'b0011;
            wdata_d = {2{wdata_i[15:0]}};
         end
         default: begin
            be_d    = 4'b1111;
            wdata_d = wdata_i;
         end
      endcase
   end

   // Lane and size come from the registered request, not the live inputs.
   assign byte_sel = mem_rdata_i[{lane_q, 3'b000} +: 8];
   assign half_sel = mem_rdata_i[{lane_q[1], 4'b0000} +: 16];

   always_comb begin
      ext_data = mem_rdata_i;
      case (f3_q[1:0])
         2'b00:   ext_data = f3_q[2] ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
         2'b01:   ext_data = f3_q[2] ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
         default: ext_data = mem_rdata_i;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_REQ;
         S_REQ:   if (mem_gnt_i) state_d = mem_we_o ? S_DONE : S_WAIT;
         S_WAIT:  if (mem_rvalid_i) state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q     <= S_IDLE;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= 32'b0;
         mem_be_o    <= 4'b0;
         mem_wdata_o <= 32'b0;
         lane_q      <= 2'b0;
         f3_q        <= 3'b0;
         ReadData_o  <= 32'b0;
      end else begin
         state_q <= state_d;
         if (start) begin
            mem_we_o    <= ~MemRead_i;
            mem_addr_o  <= {addr_i[31:2], 2'b00};
            mem_be_o    <= be_d;
            mem_wdata_o <= wdata_d;
            lane_q      <= addr_i[1:0];
            f3_q        <= funct3_i;
         end
         if (bad)
            ReadData_o <= 32'b0;
         else if ((state_q == S_WAIT) && mem_rvalid_i)
            ReadData_o <= ext_data;
      end
   end

   assign mem_req_o = (state_q == S_REQ);
   // Gated by reset so the combinational outputs drop immediately too.
   assign stall_o   = rst_i & (start | (state_q == S_REQ) | (state_q == S_WAIT));
   assign fault_o   = rst_i & bad;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Bench for dmem_access_unit: directed cases plus random accesses checked
// against an arithmetic model of steering, extension and stall length.
module tb_dmem_access_unit;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        MemRead_i, MemWrite_i;
   logic [31:0] addr_i, wdata_i;
   logic [2:0]  funct3_i;
   logic        mem_req_o, mem_we_o;
   logic [31:0] mem_addr_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_wdata_o;
   logic        mem_gnt_i, mem_rvalid_i;
   logic [31:0] mem_rdata_i;
   logic [31:0] ReadData_o;
   logic        stall_o, fault_o;

   int nvec = 0;
   int nmis = 0;
   logic [31:0] exp_rd = 32'b0;

   always #5 clk_i = ~clk_i;

   dmem_access_unit dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
      .addr_i(addr_i), .wdata_i(wdata_i), .funct3_i(funct3_i),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
      .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
      .ReadData_o(ReadData_o), .stall_o(stall_o), .fault_o(fault_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nmis++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic ok_model(input logic [2:0] f3, input logic [31:0] a);
      int size;
      size = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : (f3 == 3'd2) ? 4 : 0;
      if (size == 0) return 1'b0;
      return (a % size) == 0;
   endfunction

   function automatic logic [3:0] be_model(input logic [2:0] f3, input logic [31:0] a);
      int ofs;
      ofs = int'(a % 4);
      if (f3[1:0] == 2'b00) return 4'(1 << ofs);
      if (f3[1:0] == 2'b01) return 4'(3 << ((ofs / 2) * 2));
      return 4'hF;
   endfunction

   function automatic logic [31:0] wd_model(input logic [2:0] f3, input logic [31:0] wd);
      if (f3[1:0] == 2'b00) return (wd & 32'hFF) * 32'h01010101;
      if (f3[1:0] == 2'b01) return (wd & 32'hFFFF) * 32'h00010001;
      return wd;
   endfunction

   function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] w);
      logic [31:0] v;
      int ofs;
      ofs = int'(a % 4);
      if (f3[1:0] == 2'b00) begin
         v = (w >> (8 * ofs)) & 32'hFF;
         if (f3[2] == 1'b0 && v >= 32'd128) v = v - 32'd256;
      end else if (f3[1:0] == 2'b01) begin
         v = (w >> (16 * (ofs / 2))) & 32'hFFFF;
         if (f3[2] == 1'b0 && v >= 32'd32768) v = v - 32'd65536;
      end else begin
         v = w;
      end
      return v;
   endfunction

   // One pipeline access; gd = refused grant cycles, rvd = cycles before rvalid.
   task automatic run_access(input logic rd, input logic wr, input logic [31:0] a,
                             input logic [31:0] wd, input logic [2:0] f3,
                             input int gd, input int rvd, input logic [31:0] word);
      int stalls, reqc, waitc, cyc, e_stalls;
      bit granted, done;
      logic [3:0]  e_be;
      logic [31:0] e_wd;
      stalls = 0; reqc = 0; waitc = 0; cyc = 0; granted = 0; done = 0;
      e_be = be_model(f3, a);
      e_wd = wd_model(f3, wd);
      e_stalls = 2 + gd + (rd ? rvd + 1 : 0);
      @(negedge clk_i);
      MemRead_i = rd; MemWrite_i = wr; addr_i = a; wdata_i = wd; funct3_i = f3;
      mem_gnt_i = 0; mem_rvalid_i = 0;
      if (!ok_model(f3, a)) begin
         #1;
         chk("fault_pulse", {31'b0, fault_o}, 32'd1);
         chk("fault_stall", {31'b0, stall_o}, 32'd0);
         chk("fault_req", {31'b0, mem_req_o}, 32'd0);
         @(negedge clk_i);
         MemRead_i = 0; MemWrite_i = 0;
         #1;
         exp_rd = 32'b0;
         chk("fault_rdata", ReadData_o, exp_rd);
         chk("fault_width", {31'b0, fault_o}, 32'd0);
         chk("fault_noreq", {31'b0, mem_req_o}, 32'd0);
         return;
      end
      while (!done && cyc < 64) begin
         #1;
         mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = $urandom;
         if (stall_o) begin
            stalls++;
            chk("no_fault", {31'b0, fault_o}, 32'd0);
            if (mem_req_o) begin
               chk("req_we", {31'b0, mem_we_o}, {31'b0, ~rd});
               chk("req_addr", mem_addr_o, a & 32'hFFFFFFFC);
               chk("req_be", {28'b0, mem_be_o}, {28'b0, e_be});
               if (!rd) chk("req_wdata", mem_wdata_o, e_wd);
               mem_rvalid_i = 1'($urandom_range(0, 1));
               if (reqc == gd) begin
                  mem_gnt_i = 1; granted = 1;
               end
               reqc++;
            end else if (granted) begin
               if (waitc == rvd) begin
                  mem_rvalid_i = 1; mem_rdata_i = word;
               end
               waitc++;
            end
         end else begin
            done = 1;
         end
         if (!done) @(negedge clk_i);
         cyc++;
      end
      chk("timeout", {31'b0, done}, 32'd1);
      chk("stall_cycles", stalls, e_stalls);
      if (rd) exp_rd = load_model(f3, a, word);
      chk("done_rdata", ReadData_o, exp_rd);
   endtask

   initial begin
      rst_i = 0;
      MemRead_i = 0; MemWrite_i = 1; addr_i = 32'h100; wdata_i = 0; funct3_i = 3'd2;
      mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
      #1;
      chk("rst_req", {31'b0, mem_req_o}, 32'd0);
      chk("rst_stall", {31'b0, stall_o}, 32'd0);
      chk("rst_rdata", ReadData_o, 32'd0);
      MemWrite_i = 0;
      @(negedge clk_i);
      @(negedge clk_i);
      rst_i = 1;

      run_access(1, 0, 32'h100, 32'h0, 3'd2, 0, 0, 32'hDEADBEEF);
      run_access(1, 0, 32'h103, 32'h0, 3'd0, 0, 1, 32'h80112233);
      run_access(1, 0, 32'h103, 32'h0, 3'd4, 1, 0, 32'h80112233);
      run_access(1, 0, 32'h102, 32'h0, 3'd5, 0, 2, 32'h80112233);
      run_access(0, 1, 32'h101, 32'h000000A5, 3'd0, 2, 0, 32'h0);
      run_access(1, 1, 32'h106, 32'h12345678, 3'd1, 0, 0, 32'h9ABC0000);
      run_access(1, 0, 32'h102, 32'h0, 3'd2, 0, 0, 32'h0);
      run_access(1, 0, 32'h200, 32'h0, 3'd2, 0, 0, 32'h0BADF00D);
      run_access(1, 0, 32'h100, 32'h0, 3'd3, 0, 0, 32'h0);

      // reset with a request outstanding
      run_access(0, 1, 32'h20C, 32'hCAFE1234, 3'd2, 0, 0, 32'h0);
      run_access(1, 0, 32'h20C, 32'h0, 3'd2, 0, 0, 32'h55AA55AA);
      @(negedge clk_i);
      MemRead_i = 1; MemWrite_i = 0; addr_i = 32'h104; funct3_i = 3'd2;
      mem_gnt_i = 0; mem_rvalid_i = 0;
      @(negedge clk_i);
      #1;
      chk("pre_rst_req", {31'b0, mem_req_o}, 32'd1);
      rst_i = 0;
      #1;
      exp_rd = 32'b0;
      chk("mid_rst_req", {31'b0, mem_req_o}, 32'd0);
      chk("mid_rst_we", {31'b0, mem_we_o}, 32'd0);
      chk("mid_rst_addr", mem_addr_o, 32'd0);
      chk("mid_rst_be", {28'b0, mem_be_o}, 32'd0);
      chk("mid_rst_wdata", mem_wdata_o, 32'd0);
      chk("mid_rst_stall", {31'b0, stall_o}, 32'd0);
      chk("mid_rst_fault", {31'b0, fault_o}, 32'd0);
      chk("mid_rst_rdata", ReadData_o, exp_rd);
      MemRead_i = 0;
      #1 rst_i = 1;

      // reset while waiting for read data, then a late rvalid
      run_access(1, 0, 32'h10C, 32'h0, 3'd2, 0, 0, 32'h13579BDF);
      @(negedge clk_i);
      MemRead_i = 1; addr_i = 32'h108; funct3_i = 3'd2;
      @(negedge clk_i);
      #1;
      chk("wrst_req", {31'b0, mem_req_o}, 32'd1);
      mem_gnt_i = 1;
      @(negedge clk_i);
      mem_gnt_i = 0;
      #1;
      chk("wrst_wait_stall", {31'b0, stall_o}, 32'd1);
      chk("wrst_wait_req", {31'b0, mem_req_o}, 32'd0);
      rst_i = 0;
      #1;
      MemRead_i = 0;
      exp_rd = 32'b0;
      chk("wrst_stall", {31'b0, stall_o}, 32'd0);
      chk("wrst_rdata0", ReadData_o, exp_rd);
      #1 rst_i = 1;
      @(negedge clk_i);
      mem_rvalid_i = 1; mem_rdata_i = 32'hCAFEF00D;
      #1;
      chk("late_rv_stall", {31'b0, stall_o}, 32'd0);
      @(negedge clk_i);
      mem_rvalid_i = 0;
      #1;
      chk("late_rv_rdata", ReadData_o, exp_rd);
      chk("late_rv_req", {31'b0, mem_req_o}, 32'd0);

      for (int i = 0; i < 40; i++) begin
         logic rd, wr;
         rd = 1'($urandom_range(0, 1));
         wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
         run_access(rd, wr, $urandom, $urandom, 3'($urandom_range(0, 7)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
